// File: rtl/parity_stream_checker_if.sv
// Beat-in / frame-result-out bundle for parity_stream_checker.
// The checker binds to the slave modport; the producer/consumer side uses master.
interface parity_stream_checker_if #(
  parameter int DATA_W = 8
);
  // valid/ready: a transfer happens on a rising edge where valid && ready;
  // the sender holds its payload stable while valid && !ready, and ready
  // never depends on valid.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              in_last;
  logic              mode_odd;
  logic              out_valid;
  logic              out_ready;
  logic              out_par;
  logic              out_err;
  logic [0:0]        fsm_state;

  modport master (
    output in_valid, in_data, in_par, in_last, mode_odd, out_ready,
    input  in_ready, out_valid, out_par, out_err, fsm_state
  );

  modport slave (
    input  in_valid, in_data, in_par, in_last, mode_odd, out_ready,
    output in_ready, out_valid, out_par, out_err, fsm_state
  );
endinterface

// File: rtl/parity_stream_checker.sv
// Streaming per-beat parity checker with a registered per-frame result.
// Optional saturating error-frame counter enabled by `define PARITY_ERRCNT_EN.
module parity_stream_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  parity_stream_checker_if.slave  bus,
  output logic [CNT_W-1:0]        err_count
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0] state;
  logic       mode_q;
  logic       acc_q;
  logic       err_q;
  logic       out_valid_q;
  logic       out_par_q;
  logic       out_err_q;

  logic accept;
  logic load;
  logic beat_xor;
  logic mode_cur;
  logic beat_err;
  logic acc_next;
  logic err_next;

  assign bus.in_ready  = !rst && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_par   = out_par_q;
  assign bus.out_err   = out_err_q;
  assign bus.fsm_state = state;

  assign accept   = bus.in_valid && bus.in_ready;
  assign load     = accept && bus.in_last;
  assign beat_xor = ^bus.in_data;
  // The mode is captured on the first beat; later beats use the latched copy.
  assign mode_cur = (state == IDLE) ? bus.mode_odd : mode_q;
  assign beat_err = (beat_xor ^ mode_cur) != bus.in_par;
  assign acc_next = (state == IDLE) ? beat_xor : (acc_q ^ beat_xor);
  assign err_next = (state == IDLE) ? beat_err : (err_q | beat_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      acc_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) mode_q <= bus.mode_odd;
      acc_q <= acc_next;
      err_q <= err_next;
      state <= bus.in_last ? IDLE : ACCUM;
    end
  end

  // A new load wins over the unload of the previous result in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_par_q   <= acc_next ^ mode_cur;
      out_err_q   <= err_next;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef PARITY_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load && err_next && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_count = cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/parity_stream_checker.md
# parity_stream_checker

Parametrised, clocked successor to the team's 3-input combinational parity gate. It accepts a stream of DATA_W-bit beats with a per-beat received parity bit, over valid/ready, and checks each beat in even or odd mode. It accumulates frame parity until `in_last` and emits one registered per-frame result (frame parity plus error flag) on a valid/ready output. It sits between a link receiver and the frame consumer.

## Interface
Parameters:
- `DATA_W`, 8: beat width in bits (≥1).
- `CNT_W`, 16: width of the error-frame counter (≥1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: block can accept a beat.
- `in_data`  in  DATA_W: beat payload.
- `in_par`  in  1: received parity bit for this beat.
- `in_last`  in  1: final beat of the frame.
- `mode_odd`  in  1: 0 = even parity, 1 = odd parity; sampled on a frame's first beat.
- `out_valid`  out  1: frame result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_par`  out  1: generated parity over all frame data bits, in the frame's mode.
- `out_err`  out  1: at least one beat in the frame failed its check.
- `err_count`  out  CNT_W: saturating count of frames with `out_err`=1.

## Operation
- **Beat accept:** a beat is accepted when `in_valid && in_ready`.
- **`in_ready`:** equals `!rst && (!out_valid || out_ready)`. It is combinational, with no dependence on `in_valid`.
- **Beat parity:** `bp = ^in_data ^ m`, where `m` is the frame's mode. The beat is in error when `bp != in_par`.
- **FSM states:**
  - IDLE: no beats accumulated.
  - ACCUM: frame in progress.
- **FSM transitions:**
  - IDLE → accept with `in_last`=0: latch `m=mode_odd`, `acc=^in_data`, `err=beat error`; go to ACCUM.
  - IDLE → accept with `in_last`=1: single-beat frame; load the result directly and stay in IDLE.
  - ACCUM → accept: `acc ^= ^in_data`, `err |= beat error`. On `in_last`, load the result and go to IDLE.
  - `mode_odd` is ignored while in ACCUM.
- **Result load:**
  - `out_par = acc_final ^ m`.
  - `out_err = err_final`.
  - `out_valid` ← 1.
  - `out_valid` clears on `out_valid && out_ready` unless a new result loads in the same cycle; a new load takes priority and replaces the register.
- **Output hold:** `out_par`/`out_err` are held stable while `out_valid && !out_ready`.
- **Reset mid-frame:** the partial frame is discarded, the FSM returns to IDLE, and any pending result is dropped.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_par`=0, `out_err`=0, `err_count`=0, FSM=IDLE.
  - `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- **Latency:** a last beat accepted at edge N gives `out_valid`=1, with the result, immediately after edge N.
- **Throughput:** one beat per cycle. Back-to-back frames, including single-beat frames, run without bubbles while `out_ready`=1.
- **Backpressure:** with `out_valid`=1 and `out_ready`=0, `in_ready`=0. No beats are lost.
- **Simultaneous events:** unload and load in the same cycle gives `out_valid` staying 1 with the new result.

## Configuration
- **`PARITY_ERRCNT_EN` defined:** `err_count` increments by 1 on each result load with `out_err`=1, and saturates at 2^CNT_W−1 with no wrap. Reset clears it.
- **`PARITY_ERRCNT_EN` undefined:** no counter register is built and `err_count` is tied to 0. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst` mid-frame after 2 beats, then release → all outputs 0. Next frame `0x0F` (last, even, `in_par`=0) → `out_par`=0, `out_err`=0.
- **Even multi-beat (DATA_W=8):** beats `0x01` (`in_par`=1), `0x03` (`in_par`=0, last) → `out_par`=1, `out_err`=0, one cycle after the last accept.
- **Odd single-beat:** `0xA5`, `mode_odd`=1, `in_par`=1, last → `out_par`=1, `out_err`=0. Toggling `mode_odd` mid-frame on a 2-beat frame has no effect.
- **Error detect:** `0x07`, even, `in_par`=0, last → `out_err`=1, and `err_count`=1 (macro on) or 0 (macro off).
- **Backpressure:**
  - Hold `out_ready`=0 for 3 cycles after a result → `in_ready`=0 and the result stays stable.
  - Raise `out_ready` together with a new last beat → the new result replaces the old, and `out_valid` stays 1.
- **Saturation:** CNT_W=2, macro on, 5 consecutive error frames → `err_count` 1, 2, 3, 3, 3.
